// File: rtl/sample_msg_combiner.sv
// Merges a sample stream and a message stream into one word stream (MSB=1 marks a message header).
// Optional macro SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN: complete messages always beat queued samples.
module sample_msg_combiner #(
  parameter int unsigned WDTH          = 32,
  parameter int unsigned MSG_LEN_WIDTH = 8,
  parameter int unsigned SMP_BUF_DEPTH = 16,
  parameter int unsigned MSG_BUF_DEPTH = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [WDTH-1:0] in_samples,
  input  logic            in_samples_nd,
  input  logic [WDTH-1:0] in_msg,
  input  logic            in_msg_nd,
  output logic [WDTH-1:0] out_data,
  output logic            out_nd,
  output logic            error
);
  localparam int unsigned SAW = $clog2(SMP_BUF_DEPTH);
  localparam int unsigned MAW = $clog2(MSG_BUF_DEPTH);
  localparam int unsigned LW  = MSG_LEN_WIDTH;
  localparam int unsigned CW  = ((MAW > LW) ? MAW : LW) + 2;

  typedef enum logic {WAIT_HDR, COLLECT} trk_state_t;
  typedef enum logic {IDLE, MSG} out_state_t;

  // Sample FIFO
  logic [WDTH-1:0] smp_mem [SMP_BUF_DEPTH];
  logic [SAW-1:0]  smp_wr_ptr, smp_rd_ptr;
  logic [SAW:0]    smp_count;
  logic            smp_full, smp_empty, smp_push, smp_pop, smp_err;
  logic [WDTH-1:0] smp_wdata;

  assign smp_full  = smp_count == (SAW+1)'(SMP_BUF_DEPTH);
  assign smp_empty = smp_count == '0;
  assign smp_push  = in_samples_nd && (!smp_full || smp_pop);
  assign smp_err   = in_samples_nd && (in_samples[WDTH-1] || (smp_full && !smp_pop));
  assign smp_wdata = {1'b0, in_samples[WDTH-2:0]};

  always_ff @(posedge clk) begin
    if (smp_push) smp_mem[smp_wr_ptr] <= smp_wdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      smp_wr_ptr <= '0;
      smp_rd_ptr <= '0;
      smp_count  <= '0;
    end else begin
      if (smp_push) smp_wr_ptr <= smp_wr_ptr + SAW'(1);
      if (smp_pop)  smp_rd_ptr <= smp_rd_ptr + SAW'(1);
      case ({smp_push, smp_pop})
        2'b10:   smp_count <= smp_count + (SAW+1)'(1);
        2'b01:   smp_count <= smp_count - (SAW+1)'(1);
        default: ;
      endcase
    end
  end

  // Message FIFO
  logic [WDTH-1:0] msg_mem [MSG_BUF_DEPTH];
  logic [MAW-1:0]  msg_wr_ptr, msg_rd_ptr;
  logic [MAW:0]    msg_count;
  logic            msg_push, msg_pop;
  logic [WDTH-1:0] msg_rd_data;
  logic [LW-1:0]   msg_head_len;

  assign msg_rd_data  = msg_mem[msg_rd_ptr];
  assign msg_head_len = msg_rd_data[WDTH-2 -: LW];

  always_ff @(posedge clk) begin
    if (msg_push) msg_mem[msg_wr_ptr] <= in_msg;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      msg_wr_ptr <= '0;
      msg_rd_ptr <= '0;
      msg_count  <= '0;
    end else begin
      if (msg_push) msg_wr_ptr <= msg_wr_ptr + MAW'(1);
      if (msg_pop)  msg_rd_ptr <= msg_rd_ptr + MAW'(1);
      case ({msg_push, msg_pop})
        2'b10:   msg_count <= msg_count + (MAW+1)'(1);
        2'b01:   msg_count <= msg_count - (MAW+1)'(1);
        default: ;
      endcase
    end
  end

  // Message write tracker: a header reserves room for its whole message or is dropped with its payload
  trk_state_t    trk_state, trk_next;
  logic [LW-1:0] trk_rem, trk_rem_next, in_len;
  logic          trk_drop, trk_drop_next, msg_done, trk_err;
  logic [CW-1:0] msg_free;

  assign in_len   = in_msg[WDTH-2 -: LW];
  assign msg_free = CW'(MSG_BUF_DEPTH) - CW'(msg_count);

  always_comb begin
    trk_next      = trk_state;
    trk_rem_next  = trk_rem;
    trk_drop_next = trk_drop;
    msg_push      = 1'b0;
    msg_done      = 1'b0;
    trk_err       = 1'b0;
    if (in_msg_nd) begin
      case (trk_state)
        WAIT_HDR: begin
          if (!in_msg[WDTH-1]) begin
            trk_err = 1'b1;
          end else if (msg_free >= CW'(in_len) + CW'(1)) begin
            msg_push = 1'b1;
            if (in_len == '0) begin
              msg_done = 1'b1;
            end else begin
              trk_next      = COLLECT;
              trk_rem_next  = in_len;
              trk_drop_next = 1'b0;
            end
          end else begin
            trk_err = 1'b1;
            if (in_len != '0) begin
              trk_next      = COLLECT;
              trk_rem_next  = in_len;
              trk_drop_next = 1'b1;
            end
          end
        end
        COLLECT: begin
          msg_push     = !trk_drop;
          trk_rem_next = trk_rem - LW'(1);
          if (trk_rem == LW'(1)) begin
            trk_next = WAIT_HDR;
            msg_done = !trk_drop;
          end
        end
        default: trk_next = WAIT_HDR;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trk_state <= WAIT_HDR;
      trk_rem   <= '0;
      trk_drop  <= 1'b0;
    end else begin
      trk_state <= trk_next;
      trk_rem   <= trk_rem_next;
      trk_drop  <= trk_drop_next;
    end
  end

  // Output FSM: a message, once started, is emitted contiguously
  out_state_t      out_state, out_next;
  logic [LW-1:0]   out_rem, out_rem_next;
  logic [MAW:0]    msgs_ready;
  logic            hdr_pop, msg_ok, out_nd_next;
  logic [WDTH-1:0] out_data_next;

`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
  assign msg_ok = msgs_ready != '0;
`else
  assign msg_ok = (msgs_ready != '0) && (smp_count <= (SAW+1)'(SMP_BUF_DEPTH / 2));
`endif

  always_comb begin
    out_next      = out_state;
    out_rem_next  = out_rem;
    out_data_next = out_data;
    out_nd_next   = 1'b0;
    smp_pop       = 1'b0;
    msg_pop       = 1'b0;
    hdr_pop       = 1'b0;
    case (out_state)
      IDLE: begin
        if (msg_ok) begin
          msg_pop       = 1'b1;
          hdr_pop       = 1'b1;
          out_data_next = msg_rd_data;
          out_nd_next   = 1'b1;
          out_rem_next  = msg_head_len;
          if (msg_head_len != '0) out_next = MSG;
        end else if (!smp_empty) begin
          smp_pop       = 1'b1;
          out_data_next = smp_mem[smp_rd_ptr];
          out_nd_next   = 1'b1;
        end
      end
      MSG: begin
        msg_pop       = 1'b1;
        out_data_next = msg_rd_data;
        out_nd_next   = 1'b1;
        out_rem_next  = out_rem - LW'(1);
        if (out_rem == LW'(1)) out_next = IDLE;
      end
      default: out_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_state  <= IDLE;
      out_rem    <= '0;
      out_data   <= '0;
      out_nd     <= 1'b0;
      error      <= 1'b0;
      msgs_ready <= '0;
    end else begin
      out_state <= out_next;
      out_rem   <= out_rem_next;
      out_data  <= out_data_next;
      out_nd    <= out_nd_next;
      error     <= error | smp_err | trk_err;
      case ({msg_done, hdr_pop})
        2'b10:   msgs_ready <= msgs_ready + (MAW+1)'(1);
        2'b01:   msgs_ready <= msgs_ready - (MAW+1)'(1);
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_sample_msg_combiner.sv
// Self-checking bench for sample_msg_combiner: queue-based reference model plus directed literal checks.
module tb_sample_msg_combiner;
  localparam int SMP_DEPTH = 16;
  localparam int MSG_DEPTH = 64;
`ifdef SAMPLE_MSG_COMBINER_MSG_PRIORITY_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic        clk, reset;
  logic [31:0] in_samples, in_msg, out_data;
  logic        in_samples_nd, in_msg_nd, out_nd, error;

  sample_msg_combiner dut (
    .clk(clk), .reset(reset),
    .in_samples(in_samples), .in_samples_nd(in_samples_nd),
    .in_msg(in_msg), .in_msg_nd(in_msg_nd),
    .out_data(out_data), .out_nd(out_nd), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: sample queue, complete-message word queue, partial message being collected
  logic [31:0] m_smp_q[$];
  logic [31:0] m_msg_q[$];
  logic [31:0] m_part[$];
  int          m_ready, m_out_left, m_trk_left, m_occ, m_len;
  bit          m_collect, m_drop, m_smp_full, m_popped;
  logic [31:0] m_data, m_w;
  bit          m_nd, m_err;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_smp_q.delete(); m_msg_q.delete(); m_part.delete();
      m_ready = 0; m_out_left = 0; m_trk_left = 0;
      m_collect = 0; m_drop = 0;
      m_data = '0; m_nd = 0; m_err = 0;
    end else begin
      m_occ      = m_msg_q.size() + m_part.size();
      m_smp_full = (m_smp_q.size() == SMP_DEPTH);
      m_popped   = 0;
      m_nd       = 0;
      if (m_out_left > 0) begin
        m_data = m_msg_q.pop_front(); m_nd = 1; m_out_left--;
      end else if (m_ready > 0 && (PRIO || m_smp_q.size() <= SMP_DEPTH / 2)) begin
        m_data = m_msg_q.pop_front(); m_nd = 1; m_ready--;
        m_out_left = int'(m_data[30:23]);
      end else if (m_smp_q.size() > 0) begin
        m_data = m_smp_q.pop_front(); m_nd = 1; m_popped = 1;
      end
      if (in_samples_nd) begin
        m_w = in_samples;
        if (m_w[31]) m_err = 1;
        m_w[31] = 1'b0;
        if (m_smp_full && !m_popped) m_err = 1;
        else m_smp_q.push_back(m_w);
      end
      if (in_msg_nd) begin
        if (!m_collect) begin
          if (!in_msg[31]) m_err = 1;
          else begin
            m_len = int'(in_msg[30:23]);
            if (MSG_DEPTH - m_occ >= m_len + 1) begin
              m_part.push_back(in_msg);
              m_drop = 0;
            end else begin
              m_err = 1;
              m_drop = 1;
            end
            m_collect = (m_len > 0); m_trk_left = m_len;
            if (m_len == 0 && !m_drop) begin
              foreach (m_part[i]) m_msg_q.push_back(m_part[i]);
              m_part.delete(); m_ready++;
            end
          end
        end else begin
          if (!m_drop) m_part.push_back(in_msg);
          m_trk_left--;
          if (m_trk_left == 0) begin
            m_collect = 0;
            if (!m_drop) begin
              foreach (m_part[i]) m_msg_q.push_back(m_part[i]);
              m_part.delete(); m_ready++;
            end
          end
        end
      end
    end
  end

  // Checking: all comparisons are made here, on the falling edge
  int          errors = 0, checks = 0;
  int          cnt_hdr = 0, cnt_pay = 0, cnt_smp = 0;
  bit          lit_valid = 0, cnt_valid = 0;
  logic        lit_nd, lit_err;
  logic [31:0] lit_data;
  string       lit_tag, cnt_tag;
  int          cnt_act, cnt_req;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endfunction

  always @(negedge clk) begin
    chk("model.out_nd", 32'(out_nd), 32'(m_nd));
    chk("model.out_data", out_data, m_data);
    chk("model.error", 32'(error), 32'(m_err));
    if (lit_valid) begin
      chk({lit_tag, ".out_nd"}, 32'(out_nd), 32'(lit_nd));
      chk({lit_tag, ".out_data"}, out_data, lit_data);
      chk({lit_tag, ".error"}, 32'(error), 32'(lit_err));
    end
    if (cnt_valid) chk(cnt_tag, 32'(cnt_act), 32'(cnt_req));
    if (out_nd) begin
      if (out_data[31]) cnt_hdr++;
      else if (out_data[30]) cnt_pay++;
      else cnt_smp++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_lit(input logic nd, input logic [31:0] d, input logic e, input string nm);
    lit_nd = nd; lit_data = d; lit_err = e; lit_tag = nm; lit_valid = 1;
    @(negedge clk); #1;
    lit_valid = 0;
  endtask

  task automatic expect_cnt(input string nm, input int act, input int req);
    cnt_tag = nm; cnt_act = act; cnt_req = req; cnt_valid = 1;
    @(negedge clk); #1;
    cnt_valid = 0;
  endtask

  int          s_hdr, s_pay, s_smp;
  logic [31:0] mw[$];

  initial begin
    reset = 1; in_samples = '0; in_msg = '0; in_samples_nd = 0; in_msg_nd = 0;
    tick(); tick();
    reset = 0;
    expect_lit(0, 32'h0, 0, "reset");

    // Samples only
    for (int k = 1; k <= 5; k++) begin
      in_samples = 32'(k); in_samples_nd = 1;
      tick();
      if (k > 1) expect_lit(1, 32'(k - 1), 0, "smp_stream");
    end
    in_samples_nd = 0;
    tick(); expect_lit(1, 32'h5, 0, "smp_last");
    tick(); expect_lit(0, 32'h5, 0, "smp_hold");

    // One message while idle
    in_msg_nd = 1; in_msg = 32'h81000000; tick();
    in_msg = 32'hDEADBEEF; tick();
    in_msg = 32'h12345678; tick();
    in_msg_nd = 0;
    tick(); expect_lit(1, 32'h81000000, 0, "msg_hdr");
    tick(); expect_lit(1, 32'hDEADBEEF, 0, "msg_p0");
    tick(); expect_lit(1, 32'h12345678, 0, "msg_p1");
    tick(); expect_lit(0, 32'h12345678, 0, "msg_end");

    // Interleaving: continuous samples with an L=3 message injected
    s_hdr = cnt_hdr; s_pay = cnt_pay; s_smp = cnt_smp;
    for (int k = 0; k < 12; k++) begin
      in_samples = 32'h100 + 32'(k); in_samples_nd = 1;
      in_msg_nd = (k >= 2 && k <= 5);
      in_msg = (k == 2) ? 32'h81800000 : 32'h40000000 + 32'(k);
      tick();
    end
    in_samples_nd = 0; in_msg_nd = 0;
    repeat (20) tick();
    expect_cnt("ilv.samples", cnt_smp - s_smp, 12);
    expect_cnt("ilv.headers", cnt_hdr - s_hdr, 1);
    expect_cnt("ilv.payload", cnt_pay - s_pay, 3);
    expect_lit(0, 32'h10B, 0, "ilv_idle");

    // Zero-length message followed by a sample
    in_msg = 32'h80000000; in_msg_nd = 1; tick();
    in_msg_nd = 0; in_samples = 32'h55; in_samples_nd = 1; tick();
    in_samples_nd = 0;
    expect_lit(1, 32'h80000000, 0, "zlen_hdr");
    tick(); expect_lit(1, 32'h55, 0, "zlen_next_smp");

    // Sample with MSB set
    in_samples = 32'h80000007; in_samples_nd = 1; tick();
    in_samples_nd = 0;
    tick(); expect_lit(1, 32'h7, 1, "smp_msb_err");
    repeat (3) tick();

    reset = 1; tick(); reset = 0; tick();
    expect_lit(0, 32'h0, 0, "post_reset");

    // Fill the message FIFO while samples hold priority, then offer an oversized header
    s_hdr = cnt_hdr; s_pay = cnt_pay; s_smp = cnt_smp;
    in_msg_nd = 1; in_msg = 32'h8A000000; tick();
    for (int p = 0; p < 20; p++) begin in_msg = 32'h42000000 + 32'(p); tick(); end
    for (int m = 0; m < 4; m++) begin
      mw.push_back(32'h87000000);
      for (int p = 0; p < 14; p++) mw.push_back(32'h40000000 + 32'(m * 256 + p));
    end
    mw.push_back(32'h85000000);
    for (int p = 0; p < 10; p++) mw.push_back(32'h4F000000 + 32'(p));
    mw.push_back(32'h80800000);
    mw.push_back(32'h41111111);
    for (int k = 1; k <= 100; k++) begin
      in_samples = 32'h1000 + 32'(k);
      in_samples_nd = (k <= 12) || (k >= 22);
      in_msg_nd = (k <= mw.size());
      if (k <= mw.size()) in_msg = mw[k - 1];
      tick();
    end
    in_samples_nd = 0; in_msg_nd = 0;
    repeat (200) tick();
    expect_cnt("fill.headers", cnt_hdr - s_hdr, 6);
    expect_cnt("fill.payload", cnt_pay - s_pay, 77);
    expect_cnt("fill.samples", cnt_smp - s_smp, 91);
    expect_cnt("fill.error", 32'(error), 1);

    // Async reset in the middle of a message payload
    in_msg_nd = 1; in_msg = 32'h81000000; tick();
    in_msg = 32'hDEADBEEF; tick();
    in_msg = 32'h12345678; tick();
    in_msg_nd = 0;
    tick(); tick();
    #2 reset = 1;
    expect_lit(0, 32'h0, 0, "async_reset");
    tick(); reset = 0;
    in_samples = 32'h9; in_samples_nd = 1; tick();
    in_samples_nd = 0;
    tick(); expect_lit(1, 32'h9, 0, "after_reset_smp");
    tick(); expect_lit(0, 32'h9, 0, "after_reset_idle");
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
